ddfs_iq_param: RTL and testbench
================================

DDFS_IQ_PARAM -- requirements
Module: ddfs_iq_param

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter ACC_W, default 16, phase accumulator width.
REQ-003 Parameter PHASE_W, default 8, truncated phase width; quarter-LUT depth is 2^(PHASE_W-2).
REQ-004 Parameter OUT_W, default 8, signed two's-complement sample width.
REQ-005 Parameter DIV, default 521, sample-tick period in clk cycles (DIV>=1).
REQ-006 Parameter FTW_INIT, default 1, tuning word loaded at reset.
REQ-007 Ports, one per line:
 clk  in  1  clock
 reset  in  1  synchronous active-high reset
 run  in  1  1 = generate, 0 = freeze tick counter and accumulator
 cfg_valid  in  1  new configuration offered
 cfg_ready  out  1  block can accept configuration
 cfg_ftw  in  ACC_W  new tuning word
 cfg_phase  in  ACC_W  phase preset
 cfg_sync  in  1  1 = load cfg_phase into accumulator on apply
 phase  out  PHASE_W  truncated phase of the current output sample
 sin_out  out  OUT_W  signed sine sample
 cos_out  out  OUT_W  signed cosine sample
 out_valid  out  1  one-cycle pulse per new sample pair

Function
REQ-008 Tick counter SHALL count 0..DIV-1 while run=1, asserting internal tick when count=DIV-1, then wrapping to 0; it holds while run=0.
REQ-009 On tick, acc SHALL update to acc+ftw modulo 2^ACC_W (wrap-around silent, no saturation).
REQ-010 Phase index p SHALL be acc[ACC_W-1 -: PHASE_W]; quadrant = p[PHASE_W-1:PHASE_W-2]; offset k = p[PHASE_W-3:0].
REQ-011 Quarter LUT entry L[k] SHALL equal round(A*sin(2*pi*(k+0.5)/2^PHASE_W)), A = 2^(OUT_W-1)-1.
REQ-012 Per quadrant 0,1,2,3: sin = +L[k], +L[M-k], -L[k], -L[M-k]; cos = +L[M-k], -L[k], -L[M-k], +L[k]; M = 2^(PHASE_W-2)-1.
REQ-013 Pipeline: stage 1 registers quadrant, k and M-k; stage 2 registers LUT reads with sign; out_valid pulses 2 cycles after the accumulator-update cycle.
REQ-014 phase SHALL be registered alongside stage 2 so it matches sin_out/cos_out in the out_valid cycle.
REQ-015 sin_out, cos_out and phase SHALL hold between out_valid pulses.
REQ-016 Config handshake: transfer when cfg_valid and cfg_ready are high at a clk edge; cfg_ftw, cfg_phase and cfg_sync are captured into pending registers and cfg_ready goes low the next cycle.
REQ-017 Pending config SHALL apply at the first tick strictly after capture: ftw <= pending ftw; if cfg_sync, acc <= cfg_phase (no increment that tick), else acc <= acc + pending ftw.
REQ-018 cfg_ready SHALL return high the cycle after apply; a capture coinciding with a tick defers to the next tick.
REQ-019 With run=0, the pending config SHALL stay pending, and no out_valid SHALL be produced once the pipeline drains.

Reset
REQ-020 Reset SHALL set acc=0, ftw=FTW_INIT, tick counter=0, pipeline registers, sin_out, cos_out and phase to 0, out_valid=0, cfg_ready=1, and pending config cleared.
REQ-021 Reset mid-operation SHALL discard pending config and in-flight samples; no out_valid SHALL appear until 2 cycles after the first post-reset tick.

Structure
REQ-022 Package ddfs_pkg SHALL hold the quadrant enum (Q0..Q3) and the constant function computing L[k] for given PHASE_W/OUT_W.
REQ-023 Sub-module ddfs_quarter_lut (combinational ROM, depth 2^(PHASE_W-2), width OUT_W-1 unsigned) SHALL be instantiated twice, once for the sine path and once for the cosine path.

Verification (ACC_W=16, PHASE_W=8, OUT_W=8, DIV=1, run=1)
REQ-024 Reset, FTW_INIT=1 -> first out_valid at cycle 3: phase=0, sin=2, cos=127.
REQ-025 Load cfg_ftw=0x4000, cfg_sync=1, cfg_phase=0 -> successive samples p=0,64,128,192 with sin 2,127,-2,-127 and cos 127,-2,-127,2.
REQ-026 cfg_ftw=0xFFFF from acc=0 -> acc wraps to 0xFFFF, p=255, sin=-2, cos=127.
REQ-027 DIV=4 -> out_valid spacing 4 cycles; run=0 for 10 cycles -> no out_valid, and outputs hold.
REQ-028 cfg_valid held high during reset and after -> cfg_ready low for exactly one tick after capture, and the new ftw is used on the next tick.
REQ-029 Reset asserted with a config pending -> ftw=FTW_INIT afterwards, and the pending config is never applied.

Source files
------------

// File: rtl/ddfs_pkg.sv
// Shared types and the quarter-wave table generator for the quadrature DDFS.
package ddfs_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_e;

    // Fixed-point scale is 2^30.
    localparam longint PI_FP = 64'sd3373259426;

    // Integer Taylor series keeps elaboration independent of real-math support.
    function automatic int lut_value(input int phase_w, input int out_w, input int k);
        longint x;
        longint term;
        longint sum;
        longint amp;
        x    = (PI_FP * longint'(2 * k + 1)) / (longint'(1) << phase_w);
        term = x;
        sum  = x;
        for (int n = 1; n <= 7; n++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        amp = (longint'(1) << (out_w - 1)) - 1;
        return int'((amp * sum + (longint'(1) << 29)) >>> 30);
    endfunction

endpackage

// File: rtl/ddfs_quarter_lut.sv
// Combinational quarter-wave ROM: unsigned magnitudes for the first quadrant.
module ddfs_quarter_lut
    import ddfs_pkg::*;
#(
    parameter int PHASE_W = 8,
    parameter int OUT_W   = 8
) (
    input  logic [PHASE_W-3:0] addr,
    output logic [OUT_W-2:0]   data
);

    localparam int DEPTH = 2 ** (PHASE_W - 2);

    logic [OUT_W-2:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam int ENTRY = lut_value(PHASE_W, OUT_W, i);
        assign rom[i] = ENTRY[OUT_W-2:0];
    end

    assign data = rom[addr];

endmodule

// File: rtl/ddfs_iq_param.sv
// Quadrature DDFS: divided sample tick, phase accumulator with a one-deep
// config handshake, and a two-stage quarter-wave sine/cosine pipeline.
module ddfs_iq_param
    import ddfs_pkg::*;
#(
    parameter int ACC_W   = 16,
    parameter int PHASE_W = 8,
    parameter int OUT_W   = 8,
    parameter int DIV     = 521,
    parameter logic [ACC_W-1:0] FTW_INIT = {{(ACC_W-1){1'b0}}, 1'b1}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [ACC_W-1:0]        cfg_ftw,
    input  logic [ACC_W-1:0]        cfg_phase,
    input  logic                    cfg_sync,
    output logic [PHASE_W-1:0]      phase,
    output logic signed [OUT_W-1:0] sin_out,
    output logic signed [OUT_W-1:0] cos_out,
    output logic                    out_valid
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam int K_W = PHASE_W - 2;
    localparam logic [K_W-1:0] K_MAX = '1;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   ftw_q, ftw_d;
    logic               pend_valid_q, pend_valid_d;
    logic [ACC_W-1:0]   pend_ftw_q, pend_ftw_d;
    logic [ACC_W-1:0]   pend_phase_q, pend_phase_d;
    logic               pend_sync_q, pend_sync_d;
    logic [PHASE_W-1:0] phase_idx;
    logic               s1_valid_q, s1_valid_d;
    quadrant_e          s1_quad_q, s1_quad_d;
    logic [K_W-1:0]     s1_k_q, s1_k_d;
    logic [K_W-1:0]     s1_mk_q, s1_mk_d;
    logic [PHASE_W-1:0] s1_phase_q, s1_phase_d;
    logic [K_W-1:0]     sin_addr, cos_addr;
    logic [OUT_W-2:0]   sin_lut, cos_lut;
    logic signed [OUT_W-1:0] sin_mag, cos_mag;
    logic signed [OUT_W-1:0] sin_val, cos_val;
    logic               out_valid_q, out_valid_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic signed [OUT_W-1:0] sin_q, sin_d;
    logic signed [OUT_W-1:0] cos_q, cos_d;

    assign cfg_ready = ~pend_valid_q;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (run) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A capture can never meet an apply: cfg_ready is low whenever something is pending.
    always_comb begin
        acc_d        = acc_q;
        ftw_d        = ftw_q;
        pend_valid_d = pend_valid_q;
        pend_ftw_d   = pend_ftw_q;
        pend_phase_d = pend_phase_q;
        pend_sync_d  = pend_sync_q;
        if (cfg_valid && cfg_ready) begin
            pend_valid_d = 1'b1;
            pend_ftw_d   = cfg_ftw;
            pend_phase_d = cfg_phase;
            pend_sync_d  = cfg_sync;
        end
        if (tick) begin
            if (pend_valid_q) begin
                ftw_d        = pend_ftw_q;
                acc_d        = pend_sync_q ? pend_phase_q : acc_q + pend_ftw_q;
                pend_valid_d = 1'b0;
            end else begin
                acc_d = acc_q + ftw_q;
            end
        end
    end

    always_comb begin
        phase_idx  = acc_d[ACC_W-1 -: PHASE_W];
        s1_valid_d = tick;
        s1_quad_d  = s1_quad_q;
        s1_k_d     = s1_k_q;
        s1_mk_d    = s1_mk_q;
        s1_phase_d = s1_phase_q;
        if (tick) begin
            s1_quad_d  = quadrant_e'(phase_idx[PHASE_W-1 -: 2]);
            s1_k_d     = phase_idx[K_W-1:0];
            s1_mk_d    = K_MAX - phase_idx[K_W-1:0];
            s1_phase_d = phase_idx;
        end
    end

    assign sin_addr = (s1_quad_q == Q1 || s1_quad_q == Q3) ? s1_mk_q : s1_k_q;
    assign cos_addr = (s1_quad_q == Q1 || s1_quad_q == Q3) ? s1_k_q : s1_mk_q;

    ddfs_quarter_lut #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) u_sin_lut (
        .addr(sin_addr),
        .data(sin_lut)
    );

    ddfs_quarter_lut #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) u_cos_lut (
        .addr(cos_addr),
        .data(cos_lut)
    );

    assign sin_mag = {1'b0, sin_lut};
    assign cos_mag = {1'b0, cos_lut};

    always_comb begin
        sin_val = sin_mag;
        cos_val = cos_mag;
        case (s1_quad_q)
            Q0: begin
                sin_val = sin_mag;
                cos_val = cos_mag;
            end
            Q1: begin
                sin_val = sin_mag;
                cos_val = -cos_mag;
            end
            Q2: begin
                sin_val = -sin_mag;
                cos_val = -cos_mag;
            end
            default: begin
                sin_val = -sin_mag;
                cos_val = cos_mag;
            end
        endcase
        out_valid_d = s1_valid_q;
        phase_d     = s1_valid_q ? s1_phase_q : phase_q;
        sin_d       = s1_valid_q ? sin_val : sin_q;
        cos_d       = s1_valid_q ? cos_val : cos_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            ftw_q        <= FTW_INIT;
            pend_valid_q <= 1'b0;
            pend_ftw_q   <= '0;
            pend_phase_q <= '0;
            pend_sync_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_quad_q    <= Q0;
            s1_k_q       <= '0;
            s1_mk_q      <= '0;
            s1_phase_q   <= '0;
            out_valid_q  <= 1'b0;
            phase_q      <= '0;
            sin_q        <= '0;
            cos_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            ftw_q        <= ftw_d;
            pend_valid_q <= pend_valid_d;
            pend_ftw_q   <= pend_ftw_d;
            pend_phase_q <= pend_phase_d;
            pend_sync_q  <= pend_sync_d;
            s1_valid_q   <= s1_valid_d;
            s1_quad_q    <= s1_quad_d;
            s1_k_q       <= s1_k_d;
            s1_mk_q      <= s1_mk_d;
            s1_phase_q   <= s1_phase_d;
            out_valid_q  <= out_valid_d;
            phase_q      <= phase_d;
            sin_q        <= sin_d;
            cos_q        <= cos_d;
        end
    end

    assign out_valid = out_valid_q;
    assign phase     = phase_q;
    assign sin_out   = sin_q;
    assign cos_out   = cos_q;

endmodule

// File: tb/tb_ddfs_iq_param.sv
// Self-checking bench for ddfs_iq_param: two instances (DIV=1 and DIV=4) share
// stimulus and are checked every cycle against an ideal-sine reference model.
module tb_ddfs_iq_param;

    localparam int ACC_W   = 16;
    localparam int PHASE_W = 8;
    localparam int OUT_W   = 8;
    localparam logic [ACC_W-1:0] FTW_INIT = 16'd1;

    logic clk = 1'b0;
    logic reset;
    logic run;
    logic cfg_valid;
    logic cfg_sync;
    logic [ACC_W-1:0] cfg_ftw;
    logic [ACC_W-1:0] cfg_phase;

    logic                    cfg_ready [2];
    logic [PHASE_W-1:0]      phase_o   [2];
    logic signed [OUT_W-1:0] sin_o     [2];
    logic signed [OUT_W-1:0] cos_o     [2];
    logic                    out_valid [2];

    int checks_total  = 0;
    int checks_passed = 0;
    int cycle_no      = 0;

    // Reference model state, one slot per instance
    bit               model_live = 1'b0;
    int               m_cnt   [2];
    logic [ACC_W-1:0] m_acc   [2];
    logic [ACC_W-1:0] m_ftw   [2];
    bit               m_pv    [2];
    logic [ACC_W-1:0] m_pf    [2];
    logic [ACC_W-1:0] m_pp    [2];
    bit               m_ps    [2];
    bit               m_sv    [2];
    int               m_sp    [2];
    bit               e_valid [2];
    int               e_phase [2];
    int               e_sin   [2];
    int               e_cos   [2];

    // Logs collected while the directed scenarios run
    int phase_log[$];
    int sin_log[$];
    int cos_log[$];
    int div4_pulse_cycles[$];
    int ready_log[$];
    bit ready_log_en = 1'b0;
    int ov_count [2];

    initial forever #5 clk = ~clk;

    ddfs_iq_param #(
        .ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .DIV(1), .FTW_INIT(FTW_INIT)
    ) u_dut_div1 (
        .clk(clk), .reset(reset), .run(run),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[0]),
        .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase), .cfg_sync(cfg_sync),
        .phase(phase_o[0]), .sin_out(sin_o[0]), .cos_out(cos_o[0]),
        .out_valid(out_valid[0])
    );

    ddfs_iq_param #(
        .ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .DIV(4), .FTW_INIT(FTW_INIT)
    ) u_dut_div4 (
        .clk(clk), .reset(reset), .run(run),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[1]),
        .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase), .cfg_sync(cfg_sync),
        .phase(phase_o[1]), .sin_out(sin_o[1]), .cos_out(cos_o[1]),
        .out_valid(out_valid[1])
    );

    // Ideal sample at the centre of phase bin p, rounded half away from zero
    function automatic int ideal_sample(input int p, input bit want_cos);
        real ang;
        real r;
        ang = 2.0 * 3.14159265358979 * ($itor(p) + 0.5) / 256.0;
        r   = want_cos ? 127.0 * $cos(ang) : 127.0 * $sin(ang);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle_no);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit rn, input bit cv,
                                 input logic [ACC_W-1:0] ftw, input logic [ACC_W-1:0] ph,
                                 input bit sync, input int ncycles);
        reset     = rst;
        run       = rn;
        cfg_valid = cv;
        cfg_ftw   = ftw;
        cfg_phase = ph;
        cfg_sync  = sync;
        repeat (ncycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One clock edge of the model: samples appear one edge after the tick that made them
    task automatic modelStep();
        for (int i = 0; i < 2; i++) begin
            int div;
            bit tick;
            bit cap;
            div = (i == 0) ? 1 : 4;
            if (reset) begin
                m_cnt[i]   = 0;
                m_acc[i]   = '0;
                m_ftw[i]   = FTW_INIT;
                m_pv[i]    = 1'b0;
                m_sv[i]    = 1'b0;
                e_valid[i] = 1'b0;
                e_phase[i] = 0;
                e_sin[i]   = 0;
                e_cos[i]   = 0;
            end else begin
                e_valid[i] = m_sv[i];
                if (m_sv[i]) begin
                    e_phase[i] = m_sp[i];
                    e_sin[i]   = ideal_sample(m_sp[i], 1'b0);
                    e_cos[i]   = ideal_sample(m_sp[i], 1'b1);
                end
                m_sv[i] = 1'b0;
                tick = run && (m_cnt[i] == div - 1);
                if (run) m_cnt[i] = tick ? 0 : m_cnt[i] + 1;
                cap = cfg_valid && !m_pv[i];
                if (tick) begin
                    if (m_pv[i]) begin
                        m_ftw[i] = m_pf[i];
                        m_acc[i] = m_ps[i] ? m_pp[i] : m_acc[i] + m_pf[i];
                        m_pv[i]  = 1'b0;
                    end else begin
                        m_acc[i] = m_acc[i] + m_ftw[i];
                    end
                    m_sv[i] = 1'b1;
                    m_sp[i] = int'(m_acc[i][ACC_W-1 -: PHASE_W]);
                end
                if (cap) begin
                    m_pv[i] = 1'b1;
                    m_pf[i] = cfg_ftw;
                    m_pp[i] = cfg_phase;
                    m_ps[i] = cfg_sync;
                end
            end
        end
        if (reset) model_live = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        cycle_no++;
        modelStep();
    end

    // Per-cycle comparison against the model, then logging for the directed checks
    initial forever begin
        @(negedge clk);
        if (model_live) begin
            for (int i = 0; i < 2; i++) begin
                string tag;
                tag = (i == 0) ? "div1" : "div4";
                checkOutput({tag, "_out_valid"}, int'(out_valid[i]), int'(e_valid[i]));
                checkOutput({tag, "_cfg_ready"}, int'(cfg_ready[i]), int'(!m_pv[i]));
                checkOutput({tag, "_phase"}, int'(phase_o[i]), e_phase[i]);
                checkOutput({tag, "_sin"}, int'(sin_o[i]), e_sin[i]);
                checkOutput({tag, "_cos"}, int'(cos_o[i]), e_cos[i]);
                if (out_valid[i] === 1'b1) ov_count[i]++;
            end
            if (out_valid[0] === 1'b1) begin
                phase_log.push_back(int'(phase_o[0]));
                sin_log.push_back(int'(sin_o[0]));
                cos_log.push_back(int'(cos_o[0]));
            end
            if (out_valid[1] === 1'b1) div4_pulse_cycles.push_back(cycle_no);
            if (ready_log_en) ready_log.push_back(int'(cfg_ready[0]));
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_valid;
        int exp_p [4];
        int exp_s [4];
        int exp_c [4];
        exp_p = '{0, 64, 128, 192};
        exp_s = '{2, 127, -2, -127};
        exp_c = '{127, -2, -127, 2};
        ov_count = '{0, 0};

        // Pin the reference model against hand-computed table values
        checkOutput("model_sin_p0", ideal_sample(0, 1'b0), 2);
        checkOutput("model_cos_p0", ideal_sample(0, 1'b1), 127);
        checkOutput("model_sin_p64", ideal_sample(64, 1'b0), 127);
        checkOutput("model_cos_p64", ideal_sample(64, 1'b1), -2);
        checkOutput("model_cos_p192", ideal_sample(192, 1'b1), 2);
        checkOutput("model_sin_p255", ideal_sample(255, 1'b0), -2);

        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 3);
        checkOutput("reset_cfg_ready", int'(cfg_ready[0]), 1);
        checkOutput("reset_out_valid", int'(out_valid[0]), 0);
        checkOutput("reset_sin", int'(sin_o[0]), 0);
        checkOutput("reset_cos", int'(cos_o[0]), 0);

        // First sample after reset: expected in cycle 3
        reset = 1'b0;
        first_valid = -1;
        for (int c = 1; c <= 10 && first_valid < 0; c++) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) first_valid = c;
        end
        checkOutput("first_valid_cycle", first_valid, 3);
        checkOutput("first_phase", int'(phase_o[0]), 0);
        checkOutput("first_sin", int'(sin_o[0]), 2);
        checkOutput("first_cos", int'(cos_o[0]), 127);
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 5);

        // Freeze: config offered while stopped stays pending, no samples emerge
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3);
        ov_count = '{0, 0};
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h4000, 16'h0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 10);
        checkOutput("freeze_pulses_div1", ov_count[0], 0);
        checkOutput("freeze_pulses_div4", ov_count[1], 0);
        checkOutput("freeze_pending_ready", int'(cfg_ready[0]), 0);

        // Quarter-turn tuning word with phase sync
        phase_log.delete(); sin_log.delete(); cos_log.delete();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 7);
        checkOutput("quarter_seq_len_ok", int'(phase_log.size() >= 4), 1);
        for (int j = 0; j < 4; j++) begin
            if (j < phase_log.size()) begin
                checkOutput($sformatf("quarter_phase_%0d", j), phase_log[j], exp_p[j]);
                checkOutput($sformatf("quarter_sin_%0d", j), sin_log[j], exp_s[j]);
                checkOutput($sformatf("quarter_cos_%0d", j), cos_log[j], exp_c[j]);
            end
        end

        // Wrap: 0 + 0xFFFF lands in the last phase bin
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0, 1'b1, 1);
        phase_log.delete(); sin_log.delete(); cos_log.delete();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 5);
        checkOutput("wrap_seq_len_ok", int'(phase_log.size() >= 2), 1);
        if (phase_log.size() >= 2) begin
            checkOutput("wrap_phase", phase_log[1], 255);
            checkOutput("wrap_sin", sin_log[1], -2);
            checkOutput("wrap_cos", cos_log[1], 127);
        end

        // DIV=4 pulse spacing
        div4_pulse_cycles.delete();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 20);
        checkOutput("div4_pulse_count_ok", int'(div4_pulse_cycles.size() >= 4), 1);
        for (int j = 1; j < div4_pulse_cycles.size(); j++) begin
            checkOutput($sformatf("div4_spacing_%0d", j),
                        div4_pulse_cycles[j] - div4_pulse_cycles[j-1], 4);
        end

        // cfg_valid held through reset and beyond
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h4000, 16'h0, 1'b0, 2);
        phase_log.delete(); sin_log.delete(); cos_log.delete();
        ready_log.delete();
        ready_log_en = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h4000, 16'h0, 1'b0, 5);
        ready_log_en = 1'b0;
        cfg_valid = 1'b0;
        checkOutput("held_ready_log_len_ok", int'(ready_log.size() >= 4), 1);
        if (ready_log.size() >= 4) begin
            checkOutput("held_ready_in_reset", ready_log[0], 1);
            checkOutput("held_ready_after_capture", ready_log[1], 0);
            checkOutput("held_ready_after_apply", ready_log[2], 1);
            checkOutput("held_ready_recapture", ready_log[3], 0);
        end
        checkOutput("held_seq_len_ok", int'(phase_log.size() >= 3), 1);
        if (phase_log.size() >= 3) begin
            checkOutput("held_phase_0", phase_log[0], 0);
            checkOutput("held_phase_new_ftw", phase_log[1], 64);
            checkOutput("held_phase_2", phase_log[2], 128);
        end

        // Reset with a config pending: it must never apply
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h2000, 16'h8000, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2);
        checkOutput("pending_before_reset_ready", int'(cfg_ready[0]), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2);
        checkOutput("pending_dropped_ready", int'(cfg_ready[0]), 1);
        phase_log.delete(); sin_log.delete(); cos_log.delete();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 6);
        checkOutput("dropped_seq_len_ok", int'(phase_log.size() >= 3), 1);
        for (int j = 0; j < 3; j++) begin
            if (j < phase_log.size()) begin
                checkOutput($sformatf("dropped_phase_%0d", j), phase_log[j], 0);
            end
        end

        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 2);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
